// File: rtl/gpi_cond_pkg.sv
// Shared constants and helpers for the gpi_cond input conditioner.
package gpi_cond_pkg;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gpi_cond_chan.sv
// One gpi_cond channel: synchroniser, debounce filter and edge flags.
// With GPI_COND_GLITCH_CNT_EN defined it also counts rejected glitches.
module gpi_cond_chan
  import gpi_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic pad_i,
`ifdef GPI_COND_GLITCH_CNT_EN
  input  logic                    glitch_clr_i,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o,
`endif
  output logic gpi_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   synced;
  logic [CW-1:0]          cnt;

  assign synced = sync_chain[SYNC_STAGES-1];

  // Shift the raw pad level through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      sync_chain <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], pad_i};
    end
  end

  // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles; flag the edge as it lands.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt    <= '0;
      gpi_o  <= RESET_VAL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (synced == gpi_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        gpi_o  <= synced;
        rise_o <= synced;
        fall_o <= ~synced;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef GPI_COND_GLITCH_CNT_EN
  logic glitch_end;

  assign glitch_end = (synced == gpi_o) && (cnt != '0);

  // Count partial runs that were abandoned, saturating; a clear takes priority.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      glitch_cnt_o <= '0;
    end else if (glitch_clr_i) begin
      glitch_cnt_o <= '0;
    end else if (glitch_end && (glitch_cnt_o != GLITCH_CNT_MAX)) begin
      glitch_cnt_o <= glitch_cnt_o + GLITCH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/gpi_cond.sv
// gpi_cond: per-bit synchronise, debounce and edge-detect of raw pad inputs.
// Optional glitch counters are enabled by defining GPI_COND_GLITCH_CNT_EN.
module gpi_cond
  import gpi_cond_pkg::*;
#(
  parameter int   WIDTH           = 1,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_in,
  input  logic [WIDTH-1:0]              pad_i,
`ifdef GPI_COND_GLITCH_CNT_EN
  input  logic                          glitch_clr_i,
  output logic [WIDTH*GLITCH_CNT_W-1:0] glitch_cnt_o,
`endif
  output logic [WIDTH-1:0]              gpi_o,
  output logic [WIDTH-1:0]              rise_o,
  output logic [WIDTH-1:0]              fall_o
);

  if (WIDTH < 1) begin : g_bad_width
    $error("gpi_cond: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gpi_cond: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("gpi_cond: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    gpi_cond_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (RESET_VAL)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_in      (rst_in),
      .pad_i       (pad_i[i]),
`ifdef GPI_COND_GLITCH_CNT_EN
      .glitch_clr_i(glitch_clr_i),
      .glitch_cnt_o(glitch_cnt_o[i*GLITCH_CNT_W +: GLITCH_CNT_W]),
`endif
      .gpi_o       (gpi_o[i]),
      .rise_o      (rise_o[i]),
      .fall_o      (fall_o[i])
    );
  end

endmodule

// File: tb/tb_gpi_cond.sv
// Testbench for gpi_cond: a 4-channel instance with default filtering and a
// 1-channel unfiltered instance, both compared every cycle against a
// history-based reference model. Honours GPI_COND_GLITCH_CNT_EN.
module tb_gpi_cond;

  localparam int   MAXC = 64;
  localparam int   SYNC = 2;
  localparam logic RV   = 1'b0;

  logic       clk_i  = 1'b0;
  logic       rst_in = 1'b0;
  logic [3:0] padA;
  logic       padB;
  logic       gclr;
  logic [3:0] gpiA, riseA, fallA;
  logic [0:0] gpiB, riseB, fallB;
`ifdef GPI_COND_GLITCH_CNT_EN
  logic [31:0] gcA;
  logic [7:0]  gcB;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: per-instance histories of sampled pad and debounced level.
  logic [3:0] padH [2][MAXC];
  logic [3:0] gH   [2][MAXC];
  int         cyc;
  logic [3:0] expGpi  [2];
  logic [3:0] expRise [2];
  logic [3:0] expFall [2];
  int         expGc   [2][4];
  int         deb [2] = '{16, 1};
  int         nch [2] = '{4, 1};

  always #5 clk_i = ~clk_i;

  gpi_cond #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_VAL(1'b0)) dutA (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .pad_i       (padA),
`ifdef GPI_COND_GLITCH_CNT_EN
    .glitch_clr_i(gclr),
    .glitch_cnt_o(gcA),
`endif
    .gpi_o       (gpiA),
    .rise_o      (riseA),
    .fall_o      (fallA)
  );

  gpi_cond #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)) dutB (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .pad_i       (padB),
`ifdef GPI_COND_GLITCH_CNT_EN
    .glitch_clr_i(gclr),
    .glitch_cnt_o(gcB),
`endif
    .gpi_o       (gpiB),
    .rise_o      (riseB),
    .fall_o      (fallB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Level seen at the end of the synchroniser after edge j (reset value until the pad has arrived).
  function automatic logic sVal(input int w, input int j, input int ch);
    int idx;
    idx = j - (SYNC - 1);
    if (idx < 1) return RV;
    return padH[w][idx % MAXC][ch];
  endfunction

  // Debounced level after edge j.
  function automatic logic gVal(input int w, input int j, input int ch);
    if (j < 1) return RV;
    return gH[w][j % MAXC][ch];
  endfunction

  task automatic modelReset();
    cyc = 0;
    for (int w = 0; w < 2; w++) begin
      expGpi[w]  = {4{RV}};
      expRise[w] = 4'b0;
      expFall[w] = 4'b0;
      for (int c = 0; c < 4; c++) expGc[w][c] = 0;
    end
  endtask

  // A new level is accepted at edge k when the last D synchronised samples all disagree with the current level.
  task automatic modelEdge(input logic clr);
    logic gPrev, gNew, allDiff, glitch;
    cyc++;
    padH[0][cyc % MAXC] = padA;
    padH[1][cyc % MAXC] = {3'b000, padB};
    for (int w = 0; w < 2; w++) begin
      gH[w][cyc % MAXC] = 4'b0;
      expRise[w] = 4'b0;
      expFall[w] = 4'b0;
      for (int ch = 0; ch < nch[w]; ch++) begin
        gPrev   = gVal(w, cyc - 1, ch);
        allDiff = 1'b1;
        for (int j = cyc - deb[w]; j < cyc; j++)
          if (sVal(w, j, ch) == gPrev) allDiff = 1'b0;
        gNew = allDiff ? ~gPrev : gPrev;
        gH[w][cyc % MAXC][ch] = gNew;
        expGpi[w][ch]  = gNew;
        expRise[w][ch] = gNew & ~gPrev;
        expFall[w][ch] = ~gNew & gPrev;
        glitch = (gVal(w, cyc - 2, ch) == gPrev) && (sVal(w, cyc - 2, ch) != gPrev)
                 && (sVal(w, cyc - 1, ch) == gPrev);
        if (clr) expGc[w][ch] = 0;
        else if (glitch && expGc[w][ch] < 255) expGc[w][ch]++;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("gpiA", gpiA, expGpi[0]);
    checkOutput("riseA", riseA, expRise[0]);
    checkOutput("fallA", fallA, expFall[0]);
    checkOutput("exclusiveA", riseA & fallA, 0);
    checkOutput("gpiB", gpiB, expGpi[1][0]);
    checkOutput("riseB", riseB, expRise[1][0]);
    checkOutput("fallB", fallB, expFall[1][0]);
`ifdef GPI_COND_GLITCH_CNT_EN
    for (int c = 0; c < 4; c++) checkOutput("glitchCntA", gcA[c*8 +: 8], expGc[0][c]);
    checkOutput("glitchCntB", gcB, expGc[1][0]);
`endif
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    modelEdge(gclr);
    @(negedge clk_i);
    checkAll();
  endtask

  // Edges from now until channel ch of dutA pulses the requested edge flag; -1 if it never does.
  task automatic countToPulse(input int ch, input bit wantRise, output int edges);
    edges = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (wantRise ? riseA[ch] : fallA[ch]) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic applyStimulus();
    int lat, pulses;
    logic [3:0] firstRise;

    // Reset with pads high; release must not pulse, acceptance after a full window.
    padA = 4'hF; padB = 1'b1; gclr = 1'b0; rst_in = 1'b0;
    modelReset();
    repeat (3) @(negedge clk_i);
    checkAll();
    rst_in = 1'b1;
    countToPulse(0, 1'b1, lat);
    checkOutput("riseLatencyAfterReset", lat, 18);
    repeat (4) tick();

    // Stable change down then up on bit 0.
    padA = 4'hE;
    countToPulse(0, 1'b0, lat);
    checkOutput("fallLatency", lat, 18);
    padA = 4'hF;
    countToPulse(0, 1'b1, lat);
    checkOutput("riseLatency", lat, 18);

    // Bring everything low, clear counters, then a 15-cycle glitch on bit 0.
    padA = 4'h0;
    repeat (25) tick();
    gclr = 1'b1;
    tick();
    gclr = 1'b0;
    padA[0] = 1'b1;
    repeat (15) tick();
    padA[0] = 1'b0;
    repeat (20) tick();
    checkOutput("glitchKeepsLow", gpiA[0], 0);
`ifdef GPI_COND_GLITCH_CNT_EN
    checkOutput("glitchCountOne", gcA[7:0], 1);
`endif

    // Unfiltered instance: toggle every 3 cycles, one pulse per toggle.
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      padB = ~padB;
      repeat (3) begin
        tick();
        if (riseB[0] || fallB[0]) pulses++;
      end
    end
    checkOutput("unfilteredPulses", pulses, 12);

    // Bits 0 and 2 rise in the same cycle.
    padA = 4'b0101;
    firstRise = 4'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (riseA != 4'b0) begin
        firstRise = riseA;
        break;
      end
    end
    checkOutput("parallelRise", firstRise, 4'b0101);

    // Asynchronous reset while bit 1 is part-way through its window.
    padA = 4'b0111;
    repeat (10) tick();
    #2 rst_in = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk_i);
    @(negedge clk_i);
    checkAll();
    rst_in = 1'b1;
    countToPulse(1, 1'b1, lat);
    checkOutput("riseAfterMidReset", lat, 18);
    repeat (4) tick();

`ifdef GPI_COND_GLITCH_CNT_EN
    // Saturation after 300 short glitches on bit 3, then a clear covering a glitch.
    for (int g = 0; g < 300; g++) begin
      padA[3] = 1'b1;
      repeat (2) tick();
      padA[3] = 1'b0;
      repeat (4) tick();
    end
    checkOutput("glitchSaturate", gcA[31:24], 255);
    gclr = 1'b1;
    padA[3] = 1'b1;
    repeat (2) tick();
    padA[3] = 1'b0;
    repeat (4) tick();
    gclr = 1'b0;
    tick();
    checkOutput("glitchClearWins", gcA[31:24], 0);
`endif

    // Random activity on all channels.
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5, 0) == 0) padA[b] = ~padA[b];
      if ($urandom_range(2, 0) == 0) padB = ~padB;
      gclr = ($urandom_range(49, 0) == 0);
      tick();
    end
    gclr = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule
